// File: rtl/sqrt_pkg.sv
// Shared types and constants for the integer square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sqrt_state_e;

  localparam int ALGO_ODD   = 0;
  localparam int ALGO_DIGIT = 1;

  function automatic int root_w(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/sqrt_unit_if.sv
// Operand request and result bundle for sqrt_unit; master issues start/a, slave returns results.
interface sqrt_unit_if #(parameter int WIDTH = 8);
  import sqrt_pkg::*;
  localparam int R = root_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [R-1:0]     root;
  logic [R:0]       rem;

  modport master (output start, output a, input busy, input done, input root, input rem);
  modport slave  (input start, input a, output busy, output done, output root, output rem);
endinterface

// File: rtl/sqrt_digit_step.sv
// One restoring root-digit step: consumes one operand bit pair, emits one root bit. Purely combinational.
module sqrt_digit_step #(
  parameter int R = 4
) (
  input  logic [R+1:0] rem_i,
  input  logic [R-1:0] root_i,
  input  logic [1:0]   pair_i,
  output logic [R+1:0] rem_o,
  output logic [R-1:0] root_o
);
  logic         ge;
  logic [R+1:0] diff;

  // Sign of the full-width trial decides the bit; the kept remainder always fits R+2 bits.
  assign ge     = {rem_i, pair_i} >= {2'b00, root_i, 2'b01};
  assign diff   = {rem_i[R-1:0], pair_i} - {root_i, 2'b01};
  assign rem_o  = ge ? diff : {rem_i[R-1:0], pair_i};
  assign root_o = {root_i[R-2:0], ge};
endmodule

// File: rtl/sqrt_unit.sv
// floor(sqrt(a)) and a-root^2; latency R+1 edges (digit) or root+2 edges (odd-sum) from start to done.
// start is taken only in IDLE or the done cycle; requests during a computation are dropped.
module sqrt_unit
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = ALGO_DIGIT
) (
  input  logic        clk,
  input  logic        clr,
  sqrt_unit_if.slave  bus
);
  localparam int R = root_w(WIDTH);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]   state_q, state_d;
  logic         done_q, done_d;
  logic [R-1:0] root_q, root_d;
  logic [R:0]   rem_q, rem_d;
  logic         accept;
  logic         calc_last;
  logic [R-1:0] res_root;
  logic [R:0]   res_rem;

  // DONE spends one cycle latching the result, then one cycle showing done.
  assign accept = bus.start && ((state_q == S_IDLE) || ((state_q == S_DONE) && done_q));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: if (calc_last) state_d = S_DONE;
      S_DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          root_d = res_root;
          rem_d  = res_rem;
        end else begin
          state_d = accept ? S_CALC : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy = (state_q == S_CALC);
  assign bus.done = done_q;
  assign bus.root = root_q;
  assign bus.rem  = rem_q;

  generate
    if (ALGO == ALGO_DIGIT) begin : g_digit
      localparam int CW = ($clog2(R) < 1) ? 1 : $clog2(R);
      logic [WIDTH-1:0] a_q;
      logic [R+1:0]     prem_q;
      logic [R-1:0]     proot_q;
      logic [CW-1:0]    cnt_q;
      logic [R+1:0]     step_rem;
      logic [R-1:0]     step_root;

      sqrt_digit_step #(.R(R)) u_step (
        .rem_i  (prem_q),
        .root_i (proot_q),
        .pair_i (a_q[WIDTH-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
      );

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          a_q     <= '0;
          prem_q  <= '0;
          proot_q <= '0;
          cnt_q   <= '0;
        end else if (accept) begin
          a_q     <= bus.a;
          prem_q  <= '0;
          proot_q <= '0;
          cnt_q   <= CW'(R - 1);
        end else if (state_q == S_CALC) begin
          a_q     <= {a_q[WIDTH-3:0], 2'b00};
          prem_q  <= step_rem;
          proot_q <= step_root;
          cnt_q   <= cnt_q - 1'b1;
        end
      end

      assign calc_last = (cnt_q == '0);
      assign res_root  = proot_q;
      assign res_rem   = prem_q[R:0];
    end else begin : g_odd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH:0]   sq_q;
      logic [R+1:0]     del_q;

      always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
          a_q   <= '0;
          sq_q  <= '0;
          del_q <= '0;
        end else if (accept) begin
          a_q   <= bus.a;
          sq_q  <= (WIDTH+1)'(1);
          del_q <= (R+2)'(3);
        end else if ((state_q == S_CALC) && !calc_last) begin
          sq_q  <= sq_q + (WIDTH+1)'(del_q);
          del_q <= del_q + (R+2)'(2);
        end
      end

      assign calc_last = (sq_q > {1'b0, a_q});
      // Both results only need their low bits, so modular arithmetic at result width suffices.
      assign res_root  = del_q[R:1] - R'(1);
      assign res_rem   = a_q[R:0] - (sq_q[R:0] - del_q[R:0] + (R+1)'(2));
    end
  endgenerate
endmodule

// File: tb/tb_sqrt_unit.sv
// Scoreboard bench: four sqrt_unit instances (8/16 bit, both algorithms) against an arithmetic root model.
module tb_sqrt_unit;
  logic        clk;
  logic        clr;
  logic        start_s [4];
  logic [15:0] a_s     [4];
  logic        busy_s  [4];
  logic        done_s  [4];
  logic [15:0] root_s  [4];
  logic [15:0] rem_s   [4];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int busy_n [4];

  typedef struct {
    int root;
    int rem;
    int due;
    int bsy;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g < 2) ? 8 : 16;
    sqrt_unit_if #(.WIDTH(W)) bus ();
    assign bus.start  = start_s[g];
    assign bus.a      = a_s[g][W-1:0];
    assign busy_s[g]  = bus.busy;
    assign done_s[g]  = bus.done;
    assign root_s[g]  = 16'(bus.root);
    assign rem_s[g]   = 16'(bus.rem);
    sqrt_unit #(.WIDTH(W), .ALGO(g % 2)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int g);
    return (g < 2) ? 8 : 16;
  endfunction

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  function automatic void chk(input string name, input int g, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", name, g, act, exp, cyc);
    end
  endfunction

  function automatic int qsize(input int g);
    case (g)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int g);
    case (g)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic void flush_all();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endfunction

  function automatic int lat_of(input int g, input int a);
    int w = width_of(g);
    int v = a & ((1 << w) - 1);
    return (g % 2 == 1) ? (w / 2 + 1) : (isqrt(v) + 2);
  endfunction

  // Expected result for operand a accepted at the edge counted as e0.
  function automatic void push(input int g, input int a, input int e0);
    exp_t e;
    int w = width_of(g);
    int v = a & ((1 << w) - 1);
    int r = isqrt(v);
    e.root = r;
    e.rem  = v - r * r;
    e.due  = e0 + lat_of(g, a);
    e.bsy  = (g % 2 == 1) ? (w / 2) : (r + 1);
    case (g)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (!clr) begin
        busy_n[g] = 0;
      end else begin
        if (busy_s[g]) busy_n[g]++;
        if (done_s[g]) begin
          chk("done_expected", g, (qsize(g) > 0) ? 1 : 0, 1);
          chk("busy_with_done", g, busy_s[g], 0);
          if (qsize(g) > 0) begin
            exp_t e;
            e = qpop(g);
            chk("root", g, root_s[g], e.root);
            chk("rem", g, rem_s[g], e.rem);
            chk("latency", g, cyc, e.due);
            chk("busy_cycles", g, busy_n[g], e.bsy);
          end
          busy_n[g] = 0;
        end
      end
    end
  end

  task automatic launch(input int a);
    for (int g = 0; g < 4; g++) begin
      a_s[g]     = 16'(a);
      start_s[g] = 1'b1;
    end
  endtask

  task automatic accept_edge(input int a);
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      push(g, a, cyc);
      start_s[g] = 1'b0;
    end
  endtask

  task automatic issue_all(input int a);
    @(negedge clk);
    launch(a);
    accept_edge(a);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && (qsize(0) + qsize(1) + qsize(2) + qsize(3)) > 0) begin
      @(posedge clk);
      #2;
      n++;
    end
    for (int g = 0; g < 4; g++) chk("pending_results", g, qsize(g), 0);
    flush_all();
  endtask

  initial begin
    int dir [6] = '{200, 0, 255, 1, 65535, 65024};
    int e0;
    int l1 [4];

    clr = 1'b0;
    for (int g = 0; g < 4; g++) begin
      start_s[g] = 1'b0;
      a_s[g]     = '0;
      busy_n[g]  = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 4; g++) begin
      chk("reset_busy", g, busy_s[g], 0);
      chk("reset_done", g, done_s[g], 0);
      chk("reset_root", g, root_s[g], 0);
      chk("reset_rem", g, rem_s[g], 0);
    end
    @(negedge clk);
    clr = 1'b1;

    foreach (dir[i]) begin
      issue_all(dir[i]);
      drain(400);
    end

    for (int a = 0; a < 256; a++) begin
      issue_all(a);
      drain(100);
    end

    for (int i = 0; i < 30; i++) begin
      issue_all(int'($urandom_range(65535)));
      drain(400);
    end

    // A second request while computing must be dropped, not queued.
    issue_all(200);
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      a_s[g]     = 16'd99;
      start_s[g] = 1'b1;
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) start_s[g] = 1'b0;
    drain(100);
    repeat (30) @(posedge clk);

    // Held start: second operand is taken in the done cycle with no idle gap.
    @(negedge clk);
    launch(16);
    @(posedge clk);
    #1;
    e0 = cyc;
    for (int g = 0; g < 4; g++) begin
      l1[g] = lat_of(g, 16);
      push(g, 16, e0);
      push(g, 17, e0 + l1[g] + 1);
      a_s[g] = 16'd17;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (cyc == e0 + l1[g] + 1) start_s[g] = 1'b0;
    end
    for (int g = 0; g < 4; g++) start_s[g] = 1'b0;
    drain(100);
    repeat (5) @(posedge clk);

    // Reset while computing clears outputs at once and discards the operand.
    issue_all(255);
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("clr_busy", g, busy_s[g], 0);
      chk("clr_done", g, done_s[g], 0);
      chk("clr_root", g, root_s[g], 0);
      chk("clr_rem", g, rem_s[g], 0);
    end
    flush_all();
    @(posedge clk);
    #2;
    clr = 1'b1;
    launch(81);
    accept_edge(81);
    drain(100);
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
